pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16: input word width in bits, range 4..32.
REQ-002 SHALL have parameter PATTERN, default 4'b1101: 4-bit pattern detected, MSB received first.
REQ-003 SHALL have parameter CNT_W, default 5: match counter width, with 2^CNT_W > WORD_W.
REQ-004 SHALL have a single clock and an asynchronous active-low reset; all other ports are synchronous to clk.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  requester presents a word.
REQ-008 SHALL have port in_ready  output  1  controller accepts a word.
REQ-009 SHALL have port in_data  input  WORD_W  word to scan.
REQ-010 SHALL have port abort  input  1  cancels the scan in progress.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port match_cnt  output  CNT_W  number of matches in the word.
REQ-014 SHALL have port match_pos  output  WORD_W  bit i set when a match completes on in_data[i].
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; in_valid&in_ready captures in_data, clears count, bitmap and detector history, and moves to SHIFT.
REQ-018 SHALL consume one bit per cycle in SHIFT, MSB first, for exactly WORD_W cycles, then move to DONE.
REQ-019 SHALL declare a match when the last 4 effective received bits equal PATTERN; on a match it increments match_cnt and sets match_pos bit of the current index.
REQ-020 SHALL start detector history empty for every word, so that no match spans two words.
REQ-021 SHALL hold out_valid=1 in DONE with match_cnt and match_pos stable; out_valid&out_ready returns the FSM to IDLE.
REQ-022 SHALL give a latency of WORD_W+1 cycles from the input handshake to out_valid; the minimum word period is WORD_W+2 cycles.
REQ-023 SHALL hold in_ready low in DONE even when out_ready=1, so the next word is accepted in IDLE at the earliest.
REQ-024 SHALL, on abort in SHIFT, go to IDLE next cycle, discard results and never assert out_valid for that word.
REQ-025 SHALL ignore abort in IDLE and DONE.
REQ-026 SHALL ignore in_data changes after capture.
REQ-027 SHALL not change match_cnt or match_pos outside SHIFT and the capture cycle.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, in_ready=0, out_valid=0, busy=0, match_cnt=0, match_pos=0 and clear the detector history.
REQ-029 SHALL raise in_ready on the first rising clk edge after rst_n deasserts.
REQ-030 SHALL, on reset mid-SHIFT or mid-DONE, lose the word and produce no result.

Configuration
REQ-031 SHALL, with OVERLAP_EN defined, retain the longest proper suffix of the matched bits after a match (for 1101 the trailing 1), so overlapping matches count.
REQ-032 SHALL, without OVERLAP_EN, clear detector history after each match, so the next match needs 4 fresh bits.

Verification
REQ-033 SHALL cover: in_data=16'hD000 -> out_valid 17 cycles after handshake, match_cnt=1, match_pos=16'h1000 (both modes).
REQ-034 SHALL cover: in_data=16'hDB00 -> OVERLAP_EN: match_cnt=2, match_pos=16'h1200; no OVERLAP_EN: match_cnt=1, match_pos=16'h1000.
REQ-035 SHALL cover: in_data=16'hDDDD -> match_cnt=4, match_pos=16'h1111; in_data=16'hFFFF -> match_cnt=0, match_pos=0.
REQ-036 SHALL cover: abort 5 cycles into SHIFT -> IDLE next cycle, no out_valid, in_ready=1 the following cycle.
REQ-037 SHALL cover: out_ready=0 for 10 cycles in DONE -> out_valid and results held stable, in_ready=0 throughout; the next word is accepted 1 cycle after the output handshake.
REQ-038 SHALL cover: rst_n pulsed low mid-SHIFT -> all outputs 0 immediately, no result for that word, in_ready=1 after release.

Source files
------------

// File: rtl/pattern_scan_ctrl_if.sv
// Handshake bundle between a word requester, the pattern_scan_ctrl scanner and the result consumer.
// Valid/ready: a transfer happens on a rising clk edge where both valid and ready are high; a
// source holds valid (and its data) until that edge, and a sink may drop ready at any time.
interface pattern_scan_ctrl_if #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  match_cnt;
  logic [WORD_W-1:0] match_pos;
  logic              busy;

  modport master (
    output in_valid, in_data, abort, out_ready,
    input  in_ready, out_valid, match_cnt, match_pos, busy
  );

  modport slave (
    input  in_valid, in_data, abort, out_ready,
    output in_ready, out_valid, match_cnt, match_pos, busy
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serial 4-bit pattern scanner: captures a word, walks it MSB first one bit per cycle, reports
// match count and match bitmap. Define OVERLAP_EN to let consecutive matches share bits.
module pattern_scan_ctrl #(
  parameter int         WORD_W  = 16,
  parameter logic [3:0] PATTERN = 4'b1101,
  parameter int         CNT_W   = 5
) (
  input logic                clk,
  input logic                rst_n,
  pattern_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(WORD_W);

`ifdef OVERLAP_EN
  // Longest proper suffix of the pattern that is also a prefix: history kept after a match.
  function automatic int keep_len_f(input logic [3:0] p);
    int ret;
    bit ok;
    ret = 0;
    for (int k = 3; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (p[j] != p[4-k+j]) ok = 1'b0;
      end
      if (ok && ret == 0) ret = k;
    end
    return ret;
  endfunction
  localparam logic [1:0] KEEP_LEN = 2'(keep_len_f(PATTERN));
`else
  localparam logic [1:0] KEEP_LEN = 2'd0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic              started_q;
  logic [WORD_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic [2:0]        hist_q;
  logic [1:0]        hist_len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] pos_q;
  logic              cur_bit;
  logic              match;
  logic              accept;

  assign cur_bit = data_q[idx_q];
  assign match   = (hist_len_q == 2'd3) && ({hist_q, cur_bit} == PATTERN);
  // started_q holds in_ready low until the first edge after reset release.
  assign accept  = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = started_q && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.match_cnt = cnt_q;
  assign bus.match_pos = pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: begin
        if (bus.abort)              state_d = IDLE;
        else if (idx_q == '0)       state_d = DONE;
      end
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q  <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      hist_q     <= '0;
      hist_len_q <= '0;
      cnt_q      <= '0;
      pos_q      <= '0;
    end else begin
      started_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q     <= bus.in_data;
            idx_q      <= IDX_W'(WORD_W - 1);
            hist_q     <= '0;
            hist_len_q <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            hist_len_q <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
            if (match) begin
              cnt_q        <= cnt_q + CNT_W'(1);
              pos_q[idx_q] <= 1'b1;
              hist_q       <= PATTERN[2:0];
              hist_len_q   <= KEEP_LEN;
            end else begin
              hist_q     <= {hist_q[1:0], cur_bit};
              hist_len_q <= (hist_len_q == 2'd3) ? 2'd3 : hist_len_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed vector table, multi-cycle corner sequences
// and random words checked against a bit-queue reference model. Honors OVERLAP_EN.
module tb_pattern_scan_ctrl;
  localparam int         W   = 16;
  localparam int         CW  = 5;
  localparam logic [3:0] PAT = 4'b1101;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   keep_len;

  pattern_scan_ctrl_if #(.WORD_W(W), .CNT_W(CW)) bus ();

  pattern_scan_ctrl #(.WORD_W(W), .PATTERN(PAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    logic [W-1:0] pos;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: keep the effective received bits in a queue, test the newest four.
  task automatic model(input logic [W-1:0] d, output int cnt, output logic [W-1:0] pos);
    logic q[$];
    logic [3:0] win;
    cnt = 0;
    pos = '0;
    for (int i = W - 1; i >= 0; i--) begin
      q.push_back(d[i]);
      if (q.size() > 4) void'(q.pop_front());
      if (q.size() == 4) begin
        win = {q[0], q[1], q[2], q[3]};
        if (win == PAT) begin
          cnt++;
          pos[i] = 1'b1;
          while (q.size() > keep_len) void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic handshake(input logic [W-1:0] d);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    check("busy_after_capture", {31'd0, bus.busy}, 32'd1);
    check("in_ready_in_shift", {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic run_word(input logic [W-1:0] d, input int ecnt, input logic [W-1:0] epos,
                          input int hold);
    int cyc;
    handshake(d);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      bus.in_data = W'($urandom);
    end
    check("latency", cyc + 1, W + 1);
    check("match_cnt", 32'(bus.match_cnt), 32'(ecnt));
    check("match_pos", 32'(bus.match_pos), 32'(epos));
    for (int h = 0; h < hold; h++) begin
      bus.abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_cnt", 32'(bus.match_cnt), 32'(ecnt));
      check("hold_pos", 32'(bus.match_pos), 32'(epos));
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("done_in_ready_with_out_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_after_out", {31'd0, bus.in_ready}, 32'd1);
    check("cnt_kept_in_idle", 32'(bus.match_cnt), 32'(ecnt));
  endtask

  task automatic watch_no_result(input string name, input int cycles);
    logic seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_cnt"}, 32'(bus.match_cnt), 32'd0);
    check({tag, "_pos"}, 32'(bus.match_pos), 32'd0);
  endtask

  initial begin
    int           ecnt;
    logic [W-1:0] epos;
    logic [W-1:0] d;
    bit           ok;

    n_checks = 0;
    n_pass   = 0;
    keep_len = 0;
`ifdef OVERLAP_EN
    for (int k = 3; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) if (PAT[j] != PAT[4-k+j]) ok = 1'b0;
      if (ok && keep_len == 0) keep_len = k;
    end
`endif

    vecs.push_back('{16'hD000, 1, 16'h1000});
`ifdef OVERLAP_EN
    vecs.push_back('{16'hDB00, 2, 16'h1200});
`else
    vecs.push_back('{16'hDB00, 1, 16'h1000});
`endif
    vecs.push_back('{16'hDDDD, 4, 16'h1111});
    vecs.push_back('{16'hFFFF, 0, 16'h0000});
    vecs.push_back('{16'h0000, 0, 16'h0000});
    vecs.push_back('{16'h000D, 1, 16'h0001});
    vecs.push_back('{16'h0D00, 1, 16'h0100});

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    check("in_ready_first_edge", {31'd0, bus.in_ready}, 32'd1);

    // abort while idle must be ignored
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // directed vector table
    foreach (vecs[i]) run_word(vecs[i].data, vecs[i].cnt, vecs[i].pos, 1);

    // consumer stalls 10 cycles in DONE (random abort pulses must be ignored)
    run_word(16'hD000, 1, 16'h1000, 10);
    // next word must be accepted on the edge right after the output handshake
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDDDD;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
    while (!bus.out_valid && n_checks < 100000) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // abort five cycles into SHIFT
    handshake(16'hD000);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    watch_no_result("abort_no_result", 25);
    check("abort_in_ready_later", {31'd0, bus.in_ready}, 32'd1);

    // reset pulse mid-SHIFT
    handshake(16'hDDDD);
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    check("midreset_ready_high", {31'd0, bus.in_ready}, 32'd1);
    watch_no_result("midreset_no_result", 25);

    // sanity of the model itself against the spec example
    model(16'hDDDD, ecnt, epos);
    check("model_dddd_cnt", 32'(ecnt), 32'd4);

    // random words against the reference model
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 2))
        0:       d = W'($urandom);
        1:       d = {4{4'($urandom_range(0, 15) | 4'b1001)}};
        default: d = W'($urandom) | 16'hDB6D;
      endcase
      model(d, ecnt, epos);
      run_word(d, ecnt, epos, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
